instr_fetch_sequencer: RTL

- Automatic fetch/issue controller between the 32-word instruction ROM and the board processor.
- Replaces manual memory-clock and processor-clock stepping: drives the ROM address, waits out ROM read latency, and presents each word on the processor's DIN.
- Asserts RUN_SIG and waits for DONE_SIG, then advances the program counter.
- Supports free-run and single-step modes, a halt address, and a DONE watchdog.

---
 rtl/fetch_seq_pkg.sv | 20 ++
 rtl/seq_watchdog.sv | 40 ++++
 rtl/instr_fetch_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared types and default widths for the instruction fetch sequencer.
package fetch_seq_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned LAT_W      = 2;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FETCH,
      ST_WAIT_ROM,
      ST_GATE,
      ST_ISSUE,
      ST_EXEC,
      ST_IMM_FETCH,
      ST_HALTED,
      ST_ERR
   } state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating cycle counter with synchronous clear; expire_o flags the enabled
// cycle that brings the count to MAX.
module seq_watchdog #(
   parameter int unsigned MAX   = 64,
   parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      expire_o = en_i && (cnt_q >= CNT_LAST);
   end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetch/issue controller: walks the program counter through the ROM, waits out
// read latency, presents each word on DIN and handshakes RUN_SIG/DONE_SIG.
module instr_fetch_sequencer
   import fetch_seq_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned ROM_LAT   = 1,
   parameter int unsigned LAST_ADDR = 31,
   parameter int unsigned WDOG_MAX  = 64
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              STEP_MODE,
   input  logic              STEP,
   output logic [ADDR_W-1:0] ROM_ADDR,
   input  logic [DATA_W-1:0] ROM_Q,
   output logic [DATA_W-1:0] DIN,
   output logic              RUN_SIG,
   input  logic              DONE_SIG,
   input  logic              IMM_REQ,
   output logic              BUSY,
   output logic              HALTED,
   output logic              ERR
);

   localparam logic [LAT_W-1:0]  LAT_FETCH = LAT_W'(ROM_LAT - 1);
   localparam logic [LAT_W-1:0]  LAT_IMM   = LAT_W'(ROM_LAT);
   localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(LAST_ADDR);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              wd_expire;
   logic              in_exec;

   assign in_exec = (state_q == ST_EXEC);

   seq_watchdog #(
      .MAX (WDOG_MAX)
   ) u_wdog (
      .clk_i    (CLK),
      .rst_i    (RST),
      .clr_i    (!in_exec),
      .en_i     (in_exec),
      .expire_o (wd_expire)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         lat_q   <= '0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         lat_q   <= lat_d;
         din_q   <= din_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      lat_d   = lat_q;
      din_d   = din_q;
      unique case (state_q)
         ST_IDLE, ST_HALTED, ST_ERR: begin
            if (START) begin
               pc_d    = '0;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            lat_d   = LAT_FETCH;
            state_d = ST_WAIT_ROM;
         end
         ST_WAIT_ROM: begin
            if (lat_q == '0) begin
               din_d   = ROM_Q;
               state_d = STEP_MODE ? ST_GATE : ST_ISSUE;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         ST_GATE: begin
            if (STEP) begin
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (DONE_SIG) begin
               if (pc_q == PC_LAST) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
            end else if (IMM_REQ) begin
               // No FETCH cycle precedes an immediate read, so its wait runs
               // one cycle longer to cover the address change.
               pc_d    = pc_q + ADDR_W'(1);
               lat_d   = LAT_IMM;
               state_d = ST_IMM_FETCH;
            end else if (wd_expire) begin
               state_d = ST_ERR;
            end
         end
         ST_IMM_FETCH: begin
            if (lat_q == '0) begin
               din_d   = ROM_Q;
               state_d = ST_EXEC;
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      ROM_ADDR = pc_q;
      DIN      = din_q;
      RUN_SIG  = (state_q == ST_ISSUE);
      HALTED   = (state_q == ST_HALTED);
      ERR      = (state_q == ST_ERR);
      BUSY     = !((state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_ERR));
   end

endmodule
